// File: rtl/dbus_pkg.sv
// Shared address map, STATUS bit positions and decode helper for the
// data-port responder.
package dbus_pkg;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_TOP     = 32'h0000_00FF;
  localparam logic [31:0] CYCLE_ADR   = 32'h0000_0100;
  localparam logic [31:0] CONSOLE_ADR = 32'h0000_0104;
  localparam logic [31:0] STATUS_ADR  = 32'h0000_0108;
  localparam logic [31:0] HALT_ADR    = 32'h0000_010C;

  // Byte-lane bits of the address never take part in decoding.
  localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_OVF_BIT   = 2;

  function automatic logic in_ram(input logic [31:0] adr);
    return (adr & ~RAM_TOP) == RAM_BASE;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; pop on empty is ignored and a push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is forced to zero while empty so the output is defined after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dbus_responder.sv
// Slave end of the single-cycle core's data port: 64-word RAM plus CYCLE,
// CONSOLE, STATUS and HALT registers, with combinational reads.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   adr;
  logic          sel_ram, sel_cycle, sel_console, sel_status, sel_halt;
  logic [31:0]   ram [64];
  logic [31:0]   cycle;
  logic          ovf;
  logic          fifo_full, fifo_empty, fifo_pop, console_push;
  logic [CW-1:0] fifo_count;

  assign adr         = a & WORD_MASK;
  assign sel_ram     = in_ram(adr);
  assign sel_cycle   = (adr == CYCLE_ADR);
  assign sel_console = (adr == CONSOLE_ADR);
  assign sel_status  = (adr == STATUS_ADR);
  assign sel_halt    = (adr == HALT_ADR);

  // tx handshake: a byte transfers on any edge where tx_valid & tx_ready;
  // tx_data holds steady while tx_valid is high and tx_ready is low.
  assign tx_valid     = (fifo_count != '0);
  assign fifo_pop     = tx_valid & tx_ready;
  assign console_push = we & sel_console;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (console_push),
    .din   (wd[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (we && sel_ram) ram[adr[7:2]] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle     <= '0;
      ovf       <= 1'b0;
      halt      <= 1'b0;
      halt_code <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      // A simultaneous pop makes room, so only an unmatched push overflows.
      if (console_push && fifo_full && !fifo_pop) ovf <= 1'b1;
      else if (we && sel_status && wd[STATUS_OVF_BIT]) ovf <= 1'b0;
      if (we && sel_halt && !halt) begin
        halt      <= 1'b1;
        halt_code <= wd;
      end
    end
  end

  always_comb begin
    rd = '0;
    if (sel_ram) begin
      rd = ram[adr[7:2]];
    end else if (sel_cycle) begin
      rd = cycle;
    end else if (sel_status) begin
      rd[STATUS_EMPTY_BIT] = fifo_empty;
      rd[STATUS_FULL_BIT]  = fifo_full;
      rd[STATUS_OVF_BIT]   = ovf;
    end else if (sel_halt) begin
      rd = halt_code;
    end
  end

endmodule
